// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if
// Handshake bundle between the UART receiver, the receive FIFO and the
// consumer (CPU/MMIO read path).
//   in_data/in_valid/in_ready    : sink side, receiver -> FIFO
//   out_data/out_valid/out_ready : source side, FIFO -> consumer
// Modports:
//   slave  : FIFO view (accepts in_*, drives out_data/out_valid and in_ready)
//   master : environment view (drives in_*, out_ready)
interface uart_rx_fifo_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
// Receive-side byte buffer: DEPTH-entry circular buffer, first-word-fall-
// through output. The UART line has no flow control, so input is always
// accepted; a byte arriving while full (and not being made room for by a
// simultaneous pop) is dropped and a sticky overflow flag is raised.
// Ports:
//   clk, rst      : single clock, synchronous active-high reset
//   bus (slave)   : in_data/in_valid/in_ready sink, out_data/out_valid/out_ready source
//   count         : number of stored entries
//   full          : count == DEPTH
//   overflow      : sticky drop flag, cleared by overflow_clr (set wins)
//   overflow_clr  : clears overflow (and drop_count when enabled)
//   drop_count    : saturating drop counter
// Optional feature: define UART_RX_FIFO_DROP_CNT_EN to build the 8-bit
// saturating drop counter; otherwise drop_count is tied to zero.
module uart_rx_fifo #(
  parameter  int DEPTH = 8,
  parameter  int WIDTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  uart_rx_fifo_if.slave bus,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          overflow,
  input  logic          overflow_clr,
  output logic [7:0]    drop_count
);

  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_DEPTH = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q,  count_d;
  logic             overflow_q, overflow_d;

  logic full_s, out_valid_s, pop_s, push_s, drop_s;

  assign full_s      = (count_q == CNT_DEPTH);
  assign out_valid_s = (count_q != {CW{1'b0}});
  assign pop_s       = out_valid_s & bus.out_ready;
  // A full FIFO still accepts a byte when the head leaves in the same cycle.
  assign push_s      = bus.in_valid & bus.in_ready & ~(full_s & ~pop_s);
  assign drop_s      = bus.in_valid & full_s & ~pop_s;

  // Next-state logic for pointers, occupancy and the sticky overflow flag.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    // Set has priority over clear so a drop is never lost.
    if (drop_s) begin
      overflow_d = 1'b1;
    end else if (overflow_clr) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage array; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (push_s && !rst) begin
      mem[wr_ptr_q] <= bus.in_data;
    end
  end

`ifdef UART_RX_FIFO_DROP_CNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  // Drop counter next state: a coincident clear and drop leaves exactly one.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (overflow_clr && drop_s) begin
      drop_cnt_d = 8'd1;
    end else if (overflow_clr) begin
      drop_cnt_d = 8'd0;
    end else if (drop_s && (drop_cnt_q != 8'd255)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end else begin
      drop_cnt_d = drop_cnt_q;
    end
  end

  // Drop counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt_q <= 8'd0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_count = drop_cnt_q;
`else
  assign drop_count = 8'd0;
`endif

  assign bus.in_ready  = 1'b1;
  assign bus.out_valid = out_valid_s;
  assign bus.out_data  = mem[rd_ptr_q];
  assign count         = count_q;
  assign full          = full_s;
  assign overflow      = overflow_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo
// Directed bench for uart_rx_fifo (DEPTH=8, WIDTH=8). A queue holds the bytes
// the FIFO should contain; each popped byte is compared against its head.
module tb_uart_rx_fifo;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] count;
  logic       full;
  logic       overflow;
  logic       overflow_clr;
  logic [7:0] drop_count;

  int tests_run  = 0;
  int tests_fail = 0;

  logic [7:0] sb_q[$];
  logic       m_ov;
  logic [7:0] m_dc;

  uart_rx_fifo_if #(.WIDTH(8)) bus();

  uart_rx_fifo #(.DEPTH(DEPTH), .WIDTH(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .count        (count),
    .full         (full),
    .overflow     (overflow),
    .overflow_clr (overflow_clr),
    .drop_count   (drop_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check registered status against the model after an edge.
  task automatic chk_status(input string tag);
    chk({tag, ".count"},     32'(count),         32'(sb_q.size()));
    chk({tag, ".full"},      32'(full),          32'(sb_q.size() == DEPTH));
    chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(sb_q.size() != 0));
    chk({tag, ".overflow"},  32'(overflow),      32'(m_ov));
    chk({tag, ".drop_cnt"},  32'(drop_count),    32'(m_dc));
  endtask

  // One clock cycle of stimulus; inputs are set just after the previous edge.
  task automatic cyc(input string tag, input logic iv, input logic [7:0] id,
                     input logic ordy, input logic clr);
    bit m_pop, m_full, m_drop;
    bus.in_valid  = iv;
    bus.in_data   = id;
    bus.out_ready = ordy;
    overflow_clr  = clr;
    m_full = (sb_q.size() == DEPTH);
    m_pop  = ordy && (sb_q.size() != 0);
    m_drop = iv && m_full && !m_pop;
    if (m_pop) begin
      chk({tag, ".data"}, 32'(bus.out_data), 32'(sb_q[0]));
      void'(sb_q.pop_front());
    end
    if (iv && !m_drop) sb_q.push_back(id);
    if (m_drop) m_ov = 1'b1;
    else if (clr) m_ov = 1'b0;
`ifdef UART_RX_FIFO_DROP_CNT_EN
    if (clr && m_drop) m_dc = 8'd1;
    else if (clr) m_dc = 8'd0;
    else if (m_drop && m_dc != 8'd255) m_dc = m_dc + 8'd1;
`endif
    @(posedge clk);
    #1;
    chk_status(tag);
  endtask

  // Reset with a push attempt held high to confirm it is ignored.
  task automatic do_reset(input int cycles);
    rst = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'hEE;
    bus.out_ready = 1'b0;
    overflow_clr  = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b0;
    bus.in_valid = 1'b0;
    sb_q.delete();
    m_ov = 1'b0;
    m_dc = 8'd0;
    chk_status("reset");
    chk("reset.in_ready", 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.out_ready = 1'b0;
    overflow_clr  = 1'b0;
    m_ov = 1'b0;
    m_dc = 8'd0;

    // Reset then idle
    do_reset(2);
    cyc("idle", 1'b0, 8'h00, 1'b1, 1'b0);

    // Fill three bytes, then drain them in order
    cyc("fill", 1'b1, 8'h41, 1'b0, 1'b0);
    cyc("fill", 1'b1, 8'h42, 1'b0, 1'b0);
    cyc("fill", 1'b1, 8'h43, 1'b0, 1'b0);
    chk("fill.head", 32'(bus.out_data), 32'h41);
    chk("fill.count3", 32'(count), 32'd3);
    for (int i = 0; i < 3; i++) cyc("drain3", 1'b0, 8'h00, 1'b1, 1'b0);
    chk("drain3.empty", 32'(bus.out_valid), 32'd0);

    // Empty: push with out_ready high must not pop
    cyc("emptypush", 1'b1, 8'h5A, 1'b1, 1'b0);
    chk("emptypush.count", 32'(count), 32'd1);
    cyc("emptypop", 1'b0, 8'h00, 1'b1, 1'b0);

    // Overflow: nine pushes into eight entries
    for (int i = 0; i < 9; i++) cyc("ovf", 1'b1, 8'(i), 1'b0, 1'b0);
    chk("ovf.full", 32'(full), 32'd1);
    chk("ovf.flag", 32'(overflow), 32'd1);
    for (int i = 0; i < 8; i++) cyc("ovf.drain", 1'b0, 8'h00, 1'b1, 1'b0);
    cyc("ovf.clr", 1'b0, 8'h00, 1'b0, 1'b1);

    // Full plus simultaneous pop: no drop, 0xAA drained last
    for (int i = 0; i < 8; i++) cyc("full", 1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
    cyc("fullpop", 1'b1, 8'hAA, 1'b1, 1'b0);
    chk("fullpop.count", 32'(count), 32'd8);
    chk("fullpop.ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < 8; i++) cyc("fullpop.drain", 1'b0, 8'h00, 1'b1, 1'b0);
    chk("fullpop.empty", 32'(count), 32'd0);

    // Wrap-around: twenty interleaved push/pop pairs
    for (int i = 0; i < 20; i++) begin
      cyc("wrap.push", 1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
      cyc("wrap.pop",  1'b0, 8'h00,         1'b1, 1'b0);
    end
    // Back-to-back push and pop in the same cycle
    cyc("stream", 1'b1, 8'h80, 1'b0, 1'b0);
    for (int i = 1; i < 12; i++) cyc("stream", 1'b1, 8'(8'h80 + i), 1'b1, 1'b0);
    cyc("stream.end", 1'b0, 8'h00, 1'b1, 1'b0);

    // Clear coinciding with a drop: set wins
    for (int i = 0; i < 8; i++) cyc("clr.fill", 1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
    cyc("clr.drop", 1'b1, 8'hFF, 1'b0, 1'b1);
    chk("clr.drop.ovf", 32'(overflow), 32'd1);
    cyc("clr.alone", 1'b0, 8'h00, 1'b0, 1'b1);
    chk("clr.alone.ovf", 32'(overflow), 32'd0);
    chk("clr.alone.dc", 32'(drop_count), 32'd0);

    // Reset mid-traffic with five stored bytes
    for (int i = 0; i < 3; i++) cyc("pre.rst", 1'b0, 8'h00, 1'b1, 1'b0);
    chk("pre.rst.count", 32'(count), 32'd5);
    do_reset(1);
    cyc("post.rst", 1'b1, 8'h77, 1'b0, 1'b0);
    cyc("post.rst.pop", 1'b0, 8'h00, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_fail);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side byte buffer between the UART receiver and the CPU/MMIO read path. It accepts bytes on a valid/ready sink interface, stores them in a DEPTH-entry circular buffer and presents them first-word-fall-through to the consumer. The UART line has no flow control, so the block always accepts input. When full, it drops the incoming byte and records a sticky overflow flag instead of stalling the receiver.

## Interface
- `DEPTH`, default 8: number of entries; power of two, ≥ 2.
- `WIDTH`, default 8: data width in bits.

- `clk`  in  1: single clock; all state updates on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `in_data`  in  WIDTH: byte from the UART receiver.
- `in_valid`  in  1: `in_data` is valid.
- `in_ready`  out  1: constant 1; the block never back-pressures the receiver.
- `out_data`  out  WIDTH: oldest stored byte; defined only while `out_valid` = 1.
- `out_valid`  out  1: FIFO not empty.
- `out_ready`  in  1: consumer pops the head this cycle.
- `count`  out  $clog2(DEPTH)+1: current number of stored entries.
- `full`  out  1: `count` == DEPTH.
- `overflow`  out  1: sticky; a byte was dropped since the last clear.
- `overflow_clr`  in  1: clears `overflow`.
- `drop_count`  out  8: number of dropped bytes; see Configuration.

## Operation
- Storage: `mem[DEPTH]` of WIDTH bits, with `wr_ptr` and `rd_ptr` each $clog2(DEPTH) bits.
  - Pointers wrap from DEPTH-1 to 0 by natural overflow.
  - `count` is tracked in a separate register.
- Push: `push = in_valid & in_ready & ~full_eff`.
  - `full_eff = full & ~pop`, so a push is accepted into a full FIFO if a pop occurs in the same cycle.
  - On push, `mem[wr_ptr] <= in_data` and `wr_ptr` increments.
- Pop: `pop = out_valid & out_ready`. On pop, `rd_ptr` increments.
- `count` update:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on both or neither.
- `out_data` = `mem[rd_ptr]` (combinational read, first-word-fall-through).
- `out_valid` = (`count` != 0).
- Drop: `in_valid & full & ~pop`.
  - The byte is discarded; `mem`, `wr_ptr` and `count` are unchanged.
  - `overflow` is set to 1.
- `overflow` precedence: if `overflow_clr` and a drop occur in the same cycle, set wins and `overflow` stays 1.
- Empty: `out_ready` is ignored. Push and `out_ready` in the same cycle while empty do not pop; the byte appears the next cycle.
- Reset: `wr_ptr`, `rd_ptr`, `count` = 0; `out_valid` = 0, `full` = 0, `overflow` = 0, `drop_count` = 0.
  - `mem` contents are not reset.
  - Reset mid-traffic discards all stored bytes.
  - A push asserted during the reset cycle is ignored.

## Timing
- Push-to-`out_valid` latency: 1 cycle. A byte pushed at edge N is visible on `out_data` after edge N.
- `count`, `full`, `overflow` and `drop_count` change only at clock edges and are registered or derived from registered state.
- There is no combinational path from `in_valid` to `out_valid`/`out_data`. The only combinational paths are `out_ready` → `mem`/pointer enables.
- Sustained throughput: one push and one pop per cycle.
- The UART receiver's `data_out_valid` pulse completes in one cycle because `in_ready` = 1.

## Configuration
- Macro: `UART_RX_FIFO_DROP_CNT_EN`.
- Defined:
  - `drop_count` is an 8-bit counter, incremented on each drop, saturating at 255.
  - `overflow_clr` also clears it to 0. If clear and drop coincide, `drop_count` is set to 1.
- Undefined:
  - `drop_count` is tied to 0 and no counter register is synthesized.
  - `overflow` behaviour is unchanged.

## Test plan
- **Reset then idle:** `rst` high 2 cycles → `count`=0, `out_valid`=0, `full`=0, `overflow`=0, `in_ready`=1.
- **Fill:** push 0x41, 0x42, 0x43 with `out_ready`=0 → `count`=3, `out_data`=0x41. Then pop 3 cycles → `out_data` reads 0x41, 0x42, 0x43 in order and `out_valid` falls after the third pop.
- **Overflow:** push 9 bytes 0x00..0x08 at DEPTH=8 with no pops → `full`=1, `count`=8, `overflow`=1, `drop_count`=1 (macro on); drained data is 0x00..0x07.
- **Full plus simultaneous pop:** with FIFO full, push 0xAA while popping → no drop, `count` stays 8, `overflow` stays 0, and 0xAA is the last byte drained.
- **Wrap-around:** run 20 push/pop pairs interleaved at DEPTH=8 → output order matches input, `count` never exceeds 1.
- **Clear and reset mid-operation:** `overflow_clr` in the same cycle as a drop → `overflow`=1. Then `overflow_clr` alone → 0, `drop_count`=0. Then `rst` with `count`=5 → `count`=0 next cycle.
